cache_arbiter: RTL and testbench
================================

# cache_arbiter

Two-port to one-port arbiter between the instruction-cache and data-cache physical-memory ports and the single cacheline adaptor. Each cache's miss/writeback traffic (256-bit lines, 32-bit line-aligned addresses) arrives on its own port. The arbiter grants one requester at a time, latches its request, and runs exactly one cacheline transaction downstream. It then returns a one-cycle response with registered read data.

## Interface
Parameters:
- s_line, 256, cacheline width in bits
- s_addr, 32, address width

Ports:
- clk  in  1  clock; single clock domain, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- i_pmem_read  in  1  I-cache line read request, held until i_pmem_resp
- i_pmem_address  in  s_addr  I-cache line address
- i_pmem_rdata  out  s_line  read line to I-cache
- i_pmem_resp  out  1  I-cache transaction complete, one-cycle pulse
- d_pmem_read  in  1  D-cache line read request
- d_pmem_write  in  1  D-cache line writeback request
- d_pmem_address  in  s_addr  D-cache line address
- d_pmem_wdata  in  s_line  D-cache writeback line
- d_pmem_rdata  out  s_line  read line to D-cache
- d_pmem_resp  out  1  D-cache transaction complete, one-cycle pulse
- ca_read  out  1  read request to cacheline adaptor
- ca_write  out  1  write request to cacheline adaptor
- ca_address  out  s_addr  address to adaptor
- ca_wdata  out  s_line  write line to adaptor
- ca_rdata  in  s_line  read line from adaptor, valid with ca_resp
- ca_resp  in  1  adaptor transaction done, one-cycle pulse

## Operation
- FSM states: IDLE, SERVE_I, SERVE_D, RESP.
- IDLE, no request: stay in IDLE.
- IDLE, one requester active: grant it. The next state is SERVE_I or SERVE_D.
- IDLE, both active: round-robin. Grant the port not granted last.
  - last_grant resets to D, so the first tie goes to I.
  - last_grant updates on every grant.
- On grant, latch into registers:
  - address
  - op (read/write)
  - wdata (D only)
  - granted port
- I-port ops are always read.
- D-port read and write both high: write wins. This is an illegal input, and the read is dropped. The bench flags it as an assertion.
- SERVE_I / SERVE_D:
  - Drive ca_read/ca_write/ca_address/ca_wdata from the latched registers.
  - Hold these constant until ca_resp.
  - Requester input changes during this phase are ignored.
- On ca_resp in SERVE_x:
  - Capture ca_rdata into rdata_reg (write transactions included; the value is don't-care).
  - Deassert ca_read/ca_write.
  - Go to RESP.
- RESP:
  - Assert the granted port's resp for exactly one cycle. The other port's resp stays 0.
  - Then go to IDLE.
- i_pmem_rdata and d_pmem_rdata are both driven from rdata_reg.
  - They hold the last captured line until the next ca_resp.
  - Requesters sample rdata only with their resp.
- ca_resp outside SERVE_x (IDLE, RESP): ignore it, with no state or data change.
- Requesters drop or change their request the cycle after their resp. A new request in the IDLE cycle following RESP is legal and arbitrated normally. Example: a D-cache writeback followed by an allocate read.

## Timing
- Reset values:
  - state = IDLE, last_grant = D
  - ca_read = ca_write = 0
  - i_pmem_resp = d_pmem_resp = 0
  - rdata_reg = 0, ca_address = 0, ca_wdata = 0
- All outputs are registered. No combinational path from requester inputs to ca_* outputs.
- Request present in IDLE at cycle N: ca_read/ca_write is high from cycle N+1.
- ca_resp at cycle M:
  - ca_read/ca_write are low at M+1.
  - x_pmem_resp is high at M+1 only.
  - The FSM is back in IDLE at M+2.
- Minimum overhead is 2 cycles per transaction beyond adaptor latency. Back-to-back grants are spaced by one IDLE cycle.
- Reset mid-transaction:
  - Return to IDLE and clear all outputs next cycle.
  - The in-flight adaptor transaction is abandoned.
  - A late ca_resp is ignored per the rule above.
- Starvation bound: with both ports continuously requesting, each is granted every second transaction.

## Test plan
- Lone I read:
  - Stimulus: i_pmem_read=1, addr 0x0000_1000; adaptor returns 0xA5…A5 after 5 cycles.
  - Response: ca_read high for 5 cycles with ca_address=0x0000_1000; i_pmem_resp pulses once; i_pmem_rdata=0xA5…A5; d_pmem_resp never high.
- Lone D write:
  - Stimulus: d_pmem_write=1, addr 0x0000_2040, wdata 0x1234…; adaptor resp after 3 cycles.
  - Response: ca_write=1 with that address and data held stable; d_pmem_resp single pulse.
- Tie after reset:
  - Stimulus: both request in the same cycle.
  - Response: I served first. D served next, after one IDLE cycle, without dropping its request. A second tie goes to D next time only if I was last.
- Writeback then allocate:
  - Stimulus: D write 0x0000_3000, then in the cycle after d_pmem_resp, D read 0x0000_5000.
  - Response: two separate adaptor transactions in order; each produces one d_pmem_resp.
- Reset mid-transaction:
  - Stimulus: assert rst during SERVE_D, then ca_resp arrives 2 cycles after reset.
  - Response: ca_* low the cycle after reset; no resp pulse; the stray ca_resp is ignored; the next I request is served normally.
- Spurious ca_resp in IDLE:
  - Stimulus: pulse ca_resp in IDLE with ca_rdata=0xFF…FF.
  - Response: no resp pulses; rdata_reg unchanged.

Source files
------------

// File: rtl/cache_arbiter_if.sv
// cache_arbiter_if
// Bundles every signal between the arbiter and the outside world: the
// I-cache physical-memory port, the D-cache physical-memory port and the
// cacheline-adaptor port.
//
// Modports:
//   master - the arbiter's view. It receives cache requests and adaptor
//            responses, and drives cache responses and adaptor requests.
//   slave  - the environment's view (caches plus adaptor). Directions are
//            the mirror image of master.
//
// Parameters:
//   s_line - cacheline width in bits
//   s_addr - address width in bits
interface cache_arbiter_if #(
   parameter int s_line = 256,
   parameter int s_addr = 32
);

   // I-cache port (read-only requester)
   logic              i_pmem_read;
   logic [s_addr-1:0] i_pmem_address;
   logic [s_line-1:0] i_pmem_rdata;
   logic              i_pmem_resp;

   // D-cache port (read and writeback requester)
   logic              d_pmem_read;
   logic              d_pmem_write;
   logic [s_addr-1:0] d_pmem_address;
   logic [s_line-1:0] d_pmem_wdata;
   logic [s_line-1:0] d_pmem_rdata;
   logic              d_pmem_resp;

   // Cacheline adaptor port
   logic              ca_read;
   logic              ca_write;
   logic [s_addr-1:0] ca_address;
   logic [s_line-1:0] ca_wdata;
   logic [s_line-1:0] ca_rdata;
   logic              ca_resp;

   modport master (
      input  i_pmem_read, i_pmem_address,
      input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
      input  ca_rdata, ca_resp,
      output i_pmem_rdata, i_pmem_resp,
      output d_pmem_rdata, d_pmem_resp,
      output ca_read, ca_write, ca_address, ca_wdata
   );

   modport slave (
      output i_pmem_read, i_pmem_address,
      output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
      output ca_rdata, ca_resp,
      input  i_pmem_rdata, i_pmem_resp,
      input  d_pmem_rdata, d_pmem_resp,
      input  ca_read, ca_write, ca_address, ca_wdata
   );

endinterface

// File: rtl/cache_arbiter.sv
// cache_arbiter
// Shares the single cacheline adaptor between the I-cache and the D-cache.
// One requester is granted at a time. Its address, operation and (for the
// D-cache) write line are latched, and exactly one adaptor transaction is
// run from those registers. When the adaptor responds, the returned line is
// registered and the granted cache receives a one-cycle resp pulse. Ties in
// IDLE alternate between the ports, starting with the I-cache after reset.
//
// Ports:
//   clk - single clock, all state updates on the rising edge
//   rst - synchronous, active-high reset
//   bus - cache_arbiter_if.master carrying both cache ports and the adaptor
//         port. Every output on it comes straight from a register.
module cache_arbiter #(
   parameter int s_line = 256,
   parameter int s_addr = 32
) (
   input logic            clk,
   input logic            rst,
   cache_arbiter_if.master bus
);

   typedef enum logic [1:0] {
      IDLE,
      SERVE_I,
      SERVE_D,
      RESP
   } state_t;

   state_t            state, state_next;
   logic              last_grant_d, last_grant_d_next;
   logic              ca_read_q, ca_read_next;
   logic              ca_write_q, ca_write_next;
   logic [s_addr-1:0] ca_address_q, ca_address_next;
   logic [s_line-1:0] ca_wdata_q, ca_wdata_next;
   logic [s_line-1:0] rdata_q, rdata_next;
   logic              i_resp_q, i_resp_next;
   logic              d_resp_q, d_resp_next;
   logic              i_req, d_req, pick_d;

   // Next-state and next-register logic. Every register holds its value
   // by default. Only the IDLE grant and the adaptor response in SERVE_x
   // modify the latched transaction. Because nothing here feeds an output
   // directly, no requester input can reach the ca_* pins in the same cycle.
   // D wins the grant when it is the only requester, or when both are
   // requesting and I was granted last.
   always_comb begin
      state_next        = state;
      last_grant_d_next = last_grant_d;
      ca_read_next      = ca_read_q;
      ca_write_next     = ca_write_q;
      ca_address_next   = ca_address_q;
      ca_wdata_next     = ca_wdata_q;
      rdata_next        = rdata_q;
      i_resp_next       = 1'b0;
      d_resp_next       = 1'b0;

      i_req  = bus.i_pmem_read;
      d_req  = bus.d_pmem_read | bus.d_pmem_write;
      pick_d = d_req & (~i_req | ~last_grant_d);

      case (state)
         IDLE: begin
            if (pick_d) begin
               // If read and write are both high, the write wins and the
               // read is dropped.
               state_next        = SERVE_D;
               last_grant_d_next = 1'b1;
               ca_address_next   = bus.d_pmem_address;
               ca_wdata_next     = bus.d_pmem_wdata;
               ca_write_next     = bus.d_pmem_write;
               ca_read_next      = ~bus.d_pmem_write;
            end else if (i_req) begin
               state_next        = SERVE_I;
               last_grant_d_next = 1'b0;
               ca_address_next   = bus.i_pmem_address;
               ca_read_next      = 1'b1;
               ca_write_next     = 1'b0;
            end
         end
         SERVE_I, SERVE_D: begin
            // The returned line is captured even for writes; the caches
            // only look at rdata alongside their resp.
            if (bus.ca_resp) begin
               state_next    = RESP;
               rdata_next    = bus.ca_rdata;
               ca_read_next  = 1'b0;
               ca_write_next = 1'b0;
               i_resp_next   = (state == SERVE_I);
               d_resp_next   = (state == SERVE_D);
            end
         end
         RESP: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State and output registers. Reset abandons any adaptor transaction in
   // flight. A late adaptor resp then lands in IDLE and is ignored there.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         last_grant_d <= 1'b1;
         ca_read_q    <= 1'b0;
         ca_write_q   <= 1'b0;
         ca_address_q <= '0;
         ca_wdata_q   <= '0;
         rdata_q      <= '0;
         i_resp_q     <= 1'b0;
         d_resp_q     <= 1'b0;
      end else begin
         state        <= state_next;
         last_grant_d <= last_grant_d_next;
         ca_read_q    <= ca_read_next;
         ca_write_q   <= ca_write_next;
         ca_address_q <= ca_address_next;
         ca_wdata_q   <= ca_wdata_next;
         rdata_q      <= rdata_next;
         i_resp_q     <= i_resp_next;
         d_resp_q     <= d_resp_next;
      end
   end

   // Both caches see the same registered line; each samples it only with
   // its own resp.
   assign bus.i_pmem_rdata = rdata_q;
   assign bus.d_pmem_rdata = rdata_q;
   assign bus.i_pmem_resp  = i_resp_q;
   assign bus.d_pmem_resp  = d_resp_q;
   assign bus.ca_read      = ca_read_q;
   assign bus.ca_write     = ca_write_q;
   assign bus.ca_address   = ca_address_q;
   assign bus.ca_wdata     = ca_wdata_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter
// Testbench for cache_arbiter. A transaction-level reference model predicts
// every registered output on every cycle. A vector table covers the lone
// I read, a spurious adaptor resp and a lone D write. Hand-written sequences
// cover tie arbitration, writeback followed by allocate, and reset in the
// middle of a transaction. A randomized phase then drives both caches and a
// random-latency adaptor.
module tb_cache_arbiter;

   logic clk = 1'b0;
   logic rst;
   int   tests    = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   cache_arbiter_if #(.s_line(256), .s_addr(32)) bus ();

   cache_arbiter #(.s_line(256), .s_addr(32)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Both D read and D write high at once is an illegal request pattern.
   always @(posedge clk) begin
      if (!rst)
         assert (!(bus.d_pmem_read && bus.d_pmem_write))
            else $error("[TB] illegal D request: read and write both high");
   end

   // Reference model, tracked at transaction level. busy_port is the port
   // that owns the adaptor (-1 = none, 0 = I, 1 = D). resp_port is the port
   // whose resp is visible this cycle. last_port is the most recent grant.
   int               m_busy_port;
   int               m_resp_port;
   int               m_last_port;
   logic             m_write;
   logic [31:0]      m_addr;
   logic [255:0]     m_wdata;
   logic [255:0]     m_rdata;

   task automatic checkOutput(input string name, input logic [255:0] actual,
                              input logic [255:0] expected);
      tests++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic ir, input logic [31:0] ia,
                                input logic dr, input logic dw, input logic [31:0] da,
                                input logic [255:0] dwd, input logic cr,
                                input logic [255:0] crd);
      rst                = r;
      bus.i_pmem_read    = ir;
      bus.i_pmem_address = ia;
      bus.d_pmem_read    = dr;
      bus.d_pmem_write   = dw;
      bus.d_pmem_address = da;
      bus.d_pmem_wdata   = dwd;
      bus.ca_resp        = cr;
      bus.ca_rdata       = crd;
   endtask

   // Advance the model by one cycle, using the inputs currently applied.
   task automatic modelStep();
      int winner;
      winner = -1;
      if (rst) begin
         m_busy_port = -1;
         m_resp_port = -1;
         m_last_port = 1;
         m_write     = 1'b0;
         m_addr      = '0;
         m_wdata     = '0;
         m_rdata     = '0;
      end else if (m_resp_port != -1) begin
         m_resp_port = -1;
      end else if (m_busy_port != -1) begin
         if (bus.ca_resp) begin
            m_rdata     = bus.ca_rdata;
            m_resp_port = m_busy_port;
            m_busy_port = -1;
         end
      end else begin
         if (bus.i_pmem_read && (bus.d_pmem_read || bus.d_pmem_write))
            winner = 1 - m_last_port;
         else if (bus.i_pmem_read)
            winner = 0;
         else if (bus.d_pmem_read || bus.d_pmem_write)
            winner = 1;
         if (winner == 0) begin
            m_addr  = bus.i_pmem_address;
            m_write = 1'b0;
         end else if (winner == 1) begin
            m_addr  = bus.d_pmem_address;
            m_wdata = bus.d_pmem_wdata;
            m_write = bus.d_pmem_write;
         end
         if (winner != -1) begin
            m_busy_port = winner;
            m_last_port = winner;
         end
      end
   endtask

   task automatic modelCheck();
      checkOutput("model ca_read", bus.ca_read, (m_busy_port != -1) && !m_write);
      checkOutput("model ca_write", bus.ca_write, (m_busy_port != -1) && m_write);
      checkOutput("model ca_address", bus.ca_address, m_addr);
      checkOutput("model ca_wdata", bus.ca_wdata, m_wdata);
      checkOutput("model i_pmem_resp", bus.i_pmem_resp, m_resp_port == 0);
      checkOutput("model d_pmem_resp", bus.d_pmem_resp, m_resp_port == 1);
      checkOutput("model i_pmem_rdata", bus.i_pmem_rdata, m_rdata);
      checkOutput("model d_pmem_rdata", bus.d_pmem_rdata, m_rdata);
   endtask

   // One clock cycle: predict, clock, then sample 1 ns after the edge.
   task automatic tick();
      modelStep();
      @(posedge clk);
      #1;
      modelCheck();
   endtask

   function automatic logic [255:0] randLine();
      logic [255:0] v;
      for (int w = 0; w < 8; w++) v[w*32 +: 32] = $urandom;
      return v;
   endfunction

   typedef struct packed {
      logic         rst;
      logic         i_read;
      logic [31:0]  i_addr;
      logic         d_read;
      logic         d_write;
      logic [31:0]  d_addr;
      logic [255:0] d_wdata;
      logic         ca_resp;
      logic [255:0] ca_rdata;
      logic         exp_ca_read;
      logic         exp_ca_write;
      logic [31:0]  exp_addr;
      logic [255:0] exp_wdata;
      logic         exp_i_resp;
      logic         exp_d_resp;
      logic [255:0] exp_rdata;
   } vec_t;

   function automatic vec_t mkVec(input logic r, input logic ir, input logic [31:0] ia,
                                  input logic dr, input logic dw, input logic [31:0] da,
                                  input logic [255:0] dwd, input logic cr,
                                  input logic [255:0] crd, input logic ecr,
                                  input logic ecw, input logic [31:0] ea,
                                  input logic [255:0] ew, input logic eir,
                                  input logic edr, input logic [255:0] erd);
      vec_t v;
      v = '{r, ir, ia, dr, dw, da, dwd, cr, crd, ecr, ecw, ea, ew, eir, edr, erd};
      return v;
   endfunction

   vec_t         vecs [14];
   logic [255:0] lineA5, lineC3, lineFF, line5A, wd, z;

   initial begin
      int          i_pend, d_pend, lat, resp_count;
      logic        d_is_write, cr, rr;
      logic [31:0] ia, da;
      logic [255:0] dwd, crd;

      lineA5 = {32{8'hA5}};
      lineC3 = {32{8'hC3}};
      lineFF = {256{1'b1}};
      line5A = {32{8'h5A}};
      wd     = {8{32'h1234_5678}};
      z      = '0;

      // Lone I read (5-cycle adaptor latency), spurious resp in IDLE,
      // then lone D write (3-cycle adaptor latency).
      vecs[0]  = mkVec(1, 0, 0, 0, 0, 0, z, 0, z,              0, 0, 32'h0,    z,  0, 0, z);
      vecs[1]  = mkVec(0, 1, 32'h1000, 0, 0, 0, z, 0, z,       1, 0, 32'h1000, z,  0, 0, z);
      vecs[2]  = mkVec(0, 1, 32'h1000, 0, 0, 0, z, 0, z,       1, 0, 32'h1000, z,  0, 0, z);
      vecs[3]  = mkVec(0, 1, 32'h1000, 0, 0, 0, z, 0, z,       1, 0, 32'h1000, z,  0, 0, z);
      vecs[4]  = mkVec(0, 1, 32'h1000, 0, 0, 0, z, 0, z,       1, 0, 32'h1000, z,  0, 0, z);
      vecs[5]  = mkVec(0, 1, 32'h1000, 0, 0, 0, z, 0, z,       1, 0, 32'h1000, z,  0, 0, z);
      vecs[6]  = mkVec(0, 1, 32'h1000, 0, 0, 0, z, 1, lineA5,  0, 0, 32'h1000, z,  1, 0, lineA5);
      vecs[7]  = mkVec(0, 0, 0, 0, 0, 0, z, 0, z,              0, 0, 32'h1000, z,  0, 0, lineA5);
      vecs[8]  = mkVec(0, 0, 0, 0, 0, 0, z, 1, lineFF,         0, 0, 32'h1000, z,  0, 0, lineA5);
      vecs[9]  = mkVec(0, 0, 0, 0, 1, 32'h2040, wd, 0, z,      0, 1, 32'h2040, wd, 0, 0, lineA5);
      vecs[10] = mkVec(0, 0, 0, 0, 1, 32'h2040, wd, 0, z,      0, 1, 32'h2040, wd, 0, 0, lineA5);
      vecs[11] = mkVec(0, 0, 0, 0, 1, 32'h2040, wd, 0, z,      0, 1, 32'h2040, wd, 0, 0, lineA5);
      vecs[12] = mkVec(0, 0, 0, 0, 1, 32'h2040, wd, 1, lineC3, 0, 0, 32'h2040, wd, 0, 1, lineC3);
      vecs[13] = mkVec(0, 0, 0, 0, 0, 0, z, 0, z,              0, 0, 32'h2040, wd, 0, 0, lineC3);

      applyStimulus(1, 0, 0, 0, 0, 0, z, 0, z);
      for (int k = 0; k < 14; k++) begin
         applyStimulus(vecs[k].rst, vecs[k].i_read, vecs[k].i_addr, vecs[k].d_read,
                       vecs[k].d_write, vecs[k].d_addr, vecs[k].d_wdata,
                       vecs[k].ca_resp, vecs[k].ca_rdata);
         tick();
         checkOutput($sformatf("vec%0d ca_read", k), bus.ca_read, vecs[k].exp_ca_read);
         checkOutput($sformatf("vec%0d ca_write", k), bus.ca_write, vecs[k].exp_ca_write);
         checkOutput($sformatf("vec%0d ca_address", k), bus.ca_address, vecs[k].exp_addr);
         checkOutput($sformatf("vec%0d ca_wdata", k), bus.ca_wdata, vecs[k].exp_wdata);
         checkOutput($sformatf("vec%0d i_pmem_resp", k), bus.i_pmem_resp, vecs[k].exp_i_resp);
         checkOutput($sformatf("vec%0d d_pmem_resp", k), bus.d_pmem_resp, vecs[k].exp_d_resp);
         checkOutput($sformatf("vec%0d i_pmem_rdata", k), bus.i_pmem_rdata, vecs[k].exp_rdata);
      end

      // Tie after reset: I first, then D after one IDLE cycle, then the
      // ties keep alternating.
      applyStimulus(1, 0, 0, 0, 0, 0, z, 0, z);
      tick();
      applyStimulus(0, 1, 32'h100, 1, 0, 32'h200, z, 0, z);
      tick();
      checkOutput("tie1 grant I address", bus.ca_address, 32'h100);
      applyStimulus(0, 1, 32'h100, 1, 0, 32'h200, z, 1, lineA5);
      tick();
      checkOutput("tie1 i_pmem_resp", bus.i_pmem_resp, 1);
      checkOutput("tie1 d_pmem_resp quiet", bus.d_pmem_resp, 0);
      applyStimulus(0, 0, 0, 1, 0, 32'h200, z, 0, z);
      tick();
      checkOutput("tie1 idle gap ca_read", bus.ca_read, 0);
      tick();
      checkOutput("tie1 grant D address", bus.ca_address, 32'h200);
      checkOutput("tie1 grant D ca_read", bus.ca_read, 1);
      applyStimulus(0, 0, 0, 1, 0, 32'h200, z, 1, lineC3);
      tick();
      checkOutput("tie1 d_pmem_resp", bus.d_pmem_resp, 1);
      applyStimulus(0, 1, 32'h300, 0, 1, 32'h400, wd, 0, z);
      tick();
      tick();
      checkOutput("tie2 goes to I after D", bus.ca_address, 32'h300);
      applyStimulus(0, 1, 32'h300, 0, 1, 32'h400, wd, 1, line5A);
      tick();
      checkOutput("tie2 i_pmem_resp", bus.i_pmem_resp, 1);
      applyStimulus(0, 1, 32'h500, 0, 1, 32'h400, wd, 0, z);
      tick();
      tick();
      checkOutput("tie3 goes to D after I", bus.ca_address, 32'h400);
      checkOutput("tie3 ca_write", bus.ca_write, 1);
      applyStimulus(0, 1, 32'h500, 0, 1, 32'h400, wd, 1, lineA5);
      tick();
      checkOutput("tie3 d_pmem_resp", bus.d_pmem_resp, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, z, 0, z);
      tick();
      tick();

      // Writeback, then allocate read issued in the IDLE cycle after resp.
      applyStimulus(0, 0, 0, 0, 1, 32'h3000, wd, 0, z);
      tick();
      checkOutput("wb ca_write", bus.ca_write, 1);
      checkOutput("wb ca_address", bus.ca_address, 32'h3000);
      applyStimulus(0, 0, 0, 0, 1, 32'h3000, wd, 1, lineC3);
      tick();
      checkOutput("wb d_pmem_resp", bus.d_pmem_resp, 1);
      applyStimulus(0, 0, 0, 0, 1, 32'h3000, wd, 0, z);
      tick();
      checkOutput("wb d_pmem_resp single", bus.d_pmem_resp, 0);
      applyStimulus(0, 0, 0, 1, 0, 32'h5000, z, 0, z);
      tick();
      checkOutput("alloc ca_read", bus.ca_read, 1);
      checkOutput("alloc ca_address", bus.ca_address, 32'h5000);
      applyStimulus(0, 0, 0, 1, 0, 32'h5000, z, 1, line5A);
      tick();
      checkOutput("alloc d_pmem_resp", bus.d_pmem_resp, 1);
      checkOutput("alloc d_pmem_rdata", bus.d_pmem_rdata, line5A);
      applyStimulus(0, 0, 0, 0, 0, 0, z, 0, z);
      tick();

      // Reset during SERVE_D, with a stray adaptor resp 2 cycles later.
      applyStimulus(0, 0, 0, 1, 0, 32'h6000, z, 0, z);
      tick();
      tick();
      applyStimulus(1, 0, 0, 0, 0, 0, z, 0, z);
      tick();
      checkOutput("rst ca_read", bus.ca_read, 0);
      checkOutput("rst ca_write", bus.ca_write, 0);
      checkOutput("rst ca_address", bus.ca_address, 0);
      checkOutput("rst d_pmem_resp", bus.d_pmem_resp, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, z, 0, z);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, z, 1, lineFF);
      tick();
      checkOutput("stray resp i_pmem_resp", bus.i_pmem_resp, 0);
      checkOutput("stray resp d_pmem_resp", bus.d_pmem_resp, 0);
      checkOutput("stray resp rdata", bus.i_pmem_rdata, 0);
      applyStimulus(0, 1, 32'h7000, 0, 0, 0, z, 0, z);
      tick();
      checkOutput("post-rst I ca_read", bus.ca_read, 1);
      checkOutput("post-rst I address", bus.ca_address, 32'h7000);
      applyStimulus(0, 1, 32'h7000, 0, 0, 0, z, 1, line5A);
      tick();
      checkOutput("post-rst i_pmem_resp", bus.i_pmem_resp, 1);
      checkOutput("post-rst i_pmem_rdata", bus.i_pmem_rdata, line5A);
      applyStimulus(0, 0, 0, 0, 0, 0, z, 0, z);
      tick();

      // Randomized traffic: caches hold requests until their resp, and the
      // adaptor answers after 1-6 cycles. Spurious adaptor resps and
      // occasional resets are mixed in.
      i_pend = 0; d_pend = 0; lat = 0; resp_count = 0;
      ia = 0; da = 0; dwd = z; d_is_write = 0;
      for (int c = 0; c < 3000; c++) begin
         if (bus.i_pmem_resp) begin i_pend = 0; resp_count++; end
         if (bus.d_pmem_resp) begin d_pend = 0; resp_count++; end
         if (!i_pend && $urandom_range(0, 3) == 0) begin
            i_pend = 1;
            ia = $urandom & 32'hFFFF_FFE0;
         end
         if (!d_pend && $urandom_range(0, 3) == 0) begin
            d_pend = 1;
            da = $urandom & 32'hFFFF_FFE0;
            d_is_write = $urandom_range(0, 1) == 1;
            dwd = randLine();
         end
         cr = 1'b0;
         crd = randLine();
         if (bus.ca_read || bus.ca_write) begin
            if (lat == 0) lat = $urandom_range(1, 6);
            lat--;
            if (lat == 0) cr = 1'b1;
         end else begin
            lat = 0;
            if ($urandom_range(0, 15) == 0) cr = 1'b1;
         end
         rr = ($urandom_range(0, 199) == 0);
         applyStimulus(rr, i_pend != 0, ia, (d_pend != 0) && !d_is_write,
                       (d_pend != 0) && d_is_write, da, dwd, cr, crd);
         tick();
      end
      checkOutput("random traffic made progress", resp_count > 100, 1);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
